// File: rtl/seq_arbiter_pkg.sv
// Shared definitions for the top-level sequencer and the client FSMs:
// sequencer state encoding, client index map and control bundle layout.
package seq_arbiter_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PRERST = 3'd1,
      ST_RUN    = 3'd2,
      ST_GAP    = 3'd3,
      ST_ERROR  = 3'd4
   } seq_state_t;

   // Client index map
   localparam int CLI_SCAN = 0;
   localparam int CLI_PROC = 1;
   localparam int CLI_CFG  = 2;

   // Control bundle layout (bit offsets within one client's bundle)
   localparam int CTRL_BUNDLE_W     = 32;
   localparam int CTRL_COL_CNT_PARK = 4;   // column counter parked
   localparam int CTRL_ROW_RST      = 9;   // chip row reset
   localparam int CTRL_COL_RST      = 10;  // chip column reset
   localparam int CTRL_CHIP_RST     = 11;  // chip global reset
   localparam int CTRL_RAM_RST      = 20;  // shared RAM reset

   // Bundle driven when no client owns the shared resources
   function automatic logic [CTRL_BUNDLE_W-1:0] idle_bundle();
      logic [CTRL_BUNDLE_W-1:0] b;
      b                    = '0;
      b[CTRL_COL_CNT_PARK] = 1'b1;
      b[CTRL_ROW_RST]      = 1'b1;
      b[CTRL_COL_RST]      = 1'b1;
      b[CTRL_CHIP_RST]     = 1'b1;
      b[CTRL_RAM_RST]      = 1'b1;
      return b;
   endfunction

   localparam logic [CTRL_BUNDLE_W-1:0] IDLE_CTRL_DEF = idle_bundle();

endpackage

// File: rtl/seq_next_stage.sv
// Combinational priority finder: lowest set bit of mask_i at or above
// start_i. The caller passes start_i = k+1 to search above stage k, and
// start_i = 0 to find the first stage.
module seq_next_stage #(
   parameter int N = 3
) (
   input  logic [N-1:0] mask_i,
   input  logic [3:0]   start_i,
   output logic [2:0]   idx_o,
   output logic         found_o
);

   logic [N-1:0] elig;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_elig
         assign elig[gi] = mask_i[gi] && (4'(gi) >= start_i);
      end
   endgenerate

   // Scan downwards so the lowest eligible bit is the last one written
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (elig[i]) begin
            idx_o   = 3'(i);
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_arbiter.sv
// Top-level sequencer: hands the shared RAM/counter/driver bundle to one
// client FSM at a time, in ascending index order, with an optional
// leading reset pass, a one-cycle handover gap, per-stage watchdog and
// abort.
module seq_arbiter
   import seq_arbiter_pkg::*;
#(
   parameter int                N_CLIENTS = 3,
   parameter int                CTRL_W    = 32,
   parameter int                RESET_IDX = CLI_CFG,
   parameter int                TMO_W     = 20,
   parameter logic [CTRL_W-1:0] IDLE_CTRL = CTRL_W'(IDLE_CTRL_DEF)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          i_start,
   input  logic [N_CLIENTS-1:0]          i_mode,
   input  logic                          i_pre_reset,
   input  logic                          i_abort,
   input  logic [TMO_W-1:0]              i_timeout,
   input  logic [N_CLIENTS-1:0]          i_client_end,
   input  logic [N_CLIENTS*CTRL_W-1:0]   i_client_ctrl,
   output logic [CTRL_W-1:0]             o_ctrl,
   output logic [N_CLIENTS-1:0]          o_go,
   output logic                          o_reset_pass,
   output logic [2:0]                    o_active_idx,
   output logic                          o_busy,
   output logic                          o_done,
   output logic                          o_error,
   output logic [2:0]                    o_err_idx
);

   seq_state_t             state_q, state_d;
   logic [2:0]             stage_q, stage_d;
   logic [N_CLIENTS-1:0]   mode_q, mode_d;
   logic [TMO_W-1:0]       tmo_q, tmo_d;
   logic [TMO_W-1:0]       wdog_q, wdog_d;
   logic [2:0]             nxt_idx_q, nxt_idx_d;
   logic                   nxt_found_q, nxt_found_d;
   logic                   done_q, done_d;
   logic                   error_q, error_d;
   logic [2:0]             err_idx_q, err_idx_d;

   logic                   owns;
   logic                   cur_end;
   logic                   expired;
   logic [N_CLIENTS-1:0]   owner_oh;
   logic [CTRL_W-1:0]      sel_ctrl [N_CLIENTS];
   logic [CTRL_W-1:0]      ctrl_or;
   logic [N_CLIENTS-1:0]   find_mask;
   logic [3:0]             find_start;
   logic [2:0]             find_idx;
   logic                   find_found;

   // A client owns the resources only in the reset pass or a stage
   assign owns = (state_q == ST_PRERST) || (state_q == ST_RUN);

   generate
      for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_owner
         assign owner_oh[gi] = owns && (stage_q == 3'(gi));
         assign sel_ctrl[gi] = owner_oh[gi] ? i_client_ctrl[gi*CTRL_W +: CTRL_W] : '0;
      end
   endgenerate

   // OR of the masked client bundles; at most one slice is non-zero
   always_comb begin
      ctrl_or = '0;
      for (int i = 0; i < N_CLIENTS; i++) begin
         ctrl_or = ctrl_or | sel_ctrl[i];
      end
   end

   // Only the owner's end strobe counts; others are ignored
   assign cur_end = |(i_client_end & owner_oh);
   assign expired = (tmo_q != '0) && (wdog_q == tmo_q - TMO_W'(1));

   // Finder inputs: first stage of the incoming mask when idle, otherwise
   // the stage following the current one (the reset pass precedes all)
   always_comb begin
      find_mask  = mode_q;
      find_start = {1'b0, stage_q} + 4'd1;
      if ((state_q == ST_IDLE) || (state_q == ST_ERROR)) begin
         find_mask  = i_mode;
         find_start = 4'd0;
      end else if (state_q == ST_PRERST) begin
         find_start = 4'd0;
      end
   end

   seq_next_stage #(
      .N (N_CLIENTS)
   ) u_next_stage (
      .mask_i  (find_mask),
      .start_i (find_start),
      .idx_o   (find_idx),
      .found_o (find_found)
   );

   // Next-state logic; en low freezes everything including a pending done
   always_comb begin
      state_d     = state_q;
      stage_d     = stage_q;
      mode_d      = mode_q;
      tmo_d       = tmo_q;
      wdog_d      = wdog_q;
      nxt_idx_d   = nxt_idx_q;
      nxt_found_d = nxt_found_q;
      done_d      = done_q;
      error_d     = error_q;
      err_idx_d   = err_idx_q;
      if (en) begin
         done_d = 1'b0;
         if (i_abort && (state_q != ST_IDLE)) begin
            // Abort beats end strobes, expiry and start
            state_d   = ST_IDLE;
            error_d   = 1'b0;
            err_idx_d = '0;
         end else begin
            unique case (state_q)
               ST_IDLE, ST_ERROR: begin
                  if (i_start) begin
                     error_d   = 1'b0;
                     err_idx_d = '0;
                     mode_d    = i_mode;
                     tmo_d     = i_timeout;
                     wdog_d    = '0;
                     if (i_pre_reset) begin
                        state_d = ST_PRERST;
                        stage_d = 3'(RESET_IDX);
                     end else if (find_found) begin
                        state_d = ST_RUN;
                        stage_d = find_idx;
                     end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                     end
                  end
               end
               ST_PRERST, ST_RUN: begin
                  if (cur_end) begin
                     // End wins over a same-cycle expiry; the successor
                     // is resolved now so the gap cycle just applies it
                     state_d     = ST_GAP;
                     nxt_idx_d   = find_idx;
                     nxt_found_d = find_found;
                  end else if (expired) begin
                     state_d   = ST_ERROR;
                     error_d   = 1'b1;
                     err_idx_d = stage_q;
                  end else begin
                     wdog_d = wdog_q + TMO_W'(1);
                  end
               end
               ST_GAP: begin
                  if (nxt_found_q) begin
                     state_d = ST_RUN;
                     stage_d = nxt_idx_q;
                     wdog_d  = '0;
                  end else begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end
      end
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         stage_q     <= '0;
         mode_q      <= '0;
         tmo_q       <= '0;
         wdog_q      <= '0;
         nxt_idx_q   <= '0;
         nxt_found_q <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         stage_q     <= stage_d;
         mode_q      <= mode_d;
         tmo_q       <= tmo_d;
         wdog_q      <= wdog_d;
         nxt_idx_q   <= nxt_idx_d;
         nxt_found_q <= nxt_found_d;
         done_q      <= done_d;
         error_q     <= error_d;
         err_idx_q   <= err_idx_d;
      end
   end

   assign o_ctrl       = owns ? ctrl_or : IDLE_CTRL;
   assign o_go         = owner_oh;
   assign o_reset_pass = (state_q == ST_PRERST);
   assign o_active_idx = owns ? stage_q : 3'd0;
   assign o_busy       = owns || (state_q == ST_GAP);
   assign o_done       = done_q && en;
   assign o_error      = error_q;
   assign o_err_idx    = err_idx_q;

endmodule

// File: tb/tb_seq_arbiter.sv
// Bench for seq_arbiter: directed scenarios followed by random traffic,
// every cycle checked against a plan-queue model of the sequencer.
module tb_seq_arbiter;

   localparam int          N      = 3;
   localparam int          CW     = 32;
   localparam int          RIDX   = 2;
   localparam int          TW     = 20;
   localparam logic [31:0] IDLE_E = 32'h0010_0E10;

   logic            clk = 1'b0;
   logic            rst, en, start_in, pre_in, abort_in;
   logic [N-1:0]    mode_in, end_in;
   logic [TW-1:0]   tmo_in;
   logic [N*CW-1:0] ctrl_in;
   logic [CW-1:0]   o_ctrl;
   logic [N-1:0]    o_go;
   logic            o_reset_pass, o_busy, o_done, o_error;
   logic [2:0]      o_active_idx, o_err_idx;

   int n_checks = 0;
   int n_errors = 0;
   int n_txn    = 0;

   // Model: the sequence as a list of owners, walked one entry at a time
   int plan[$];
   bit m_run, m_gap, m_pre, m_err, m_done;
   int m_pos, m_elapsed, m_tmo, m_err_idx;

   always #5 clk = ~clk;

   seq_arbiter #(
      .N_CLIENTS (N),
      .CTRL_W    (CW),
      .RESET_IDX (RIDX),
      .TMO_W     (TW),
      .IDLE_CTRL (IDLE_E)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .i_start       (start_in),
      .i_mode        (mode_in),
      .i_pre_reset   (pre_in),
      .i_abort       (abort_in),
      .i_timeout     (tmo_in),
      .i_client_end  (end_in),
      .i_client_ctrl (ctrl_in),
      .o_ctrl        (o_ctrl),
      .o_go          (o_go),
      .o_reset_pass  (o_reset_pass),
      .o_active_idx  (o_active_idx),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_error       (o_error),
      .o_err_idx     (o_err_idx)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int m_owner();
      if (m_run && !m_gap) return plan[m_pos];
      return -1;
   endfunction

   task automatic compare();
      int          ow;
      logic [31:0] e_ctrl;
      logic [N-1:0] e_go;
      ow     = m_owner();
      e_ctrl = IDLE_E;
      e_go   = '0;
      if (ow >= 0) begin
         e_ctrl   = ctrl_in[ow*CW +: CW];
         e_go[ow] = 1'b1;
      end
      check("ctrl", o_ctrl, e_ctrl);
      check("go", 32'(o_go), 32'(e_go));
      check("reset_pass", 32'(o_reset_pass), 32'(ow >= 0 && m_pre && m_pos == 0));
      check("active_idx", 32'(o_active_idx), (ow >= 0) ? 32'(ow) : 32'd0);
      check("busy", 32'(o_busy), 32'(m_run));
      check("done", 32'(o_done), 32'(m_done && en));
      check("error", 32'(o_error), 32'(m_err));
      check("err_idx", 32'(o_err_idx), 32'(m_err_idx));
   endtask

   task automatic model_step();
      int ow;
      if (rst) begin
         m_run = 0; m_gap = 0; m_err = 0; m_err_idx = 0; m_done = 0;
         return;
      end
      if (!en) return;
      m_done = 0;
      ow     = m_owner();
      if (abort_in && (m_run || m_err)) begin
         $display("txn %0d: abort (running=%0d error=%0d)", n_txn, m_run, m_err);
         n_txn++;
         m_run = 0; m_gap = 0; m_err = 0; m_err_idx = 0;
      end else if (!m_run) begin
         if (start_in) begin
            m_err = 0; m_err_idx = 0; m_pre = pre_in;
            plan.delete();
            if (pre_in) plan.push_back(RIDX);
            for (int i = 0; i < N; i++) if (mode_in[i]) plan.push_back(i);
            m_tmo = int'(tmo_in);
            if (plan.size() == 0) begin
               m_done = 1;
               $display("txn %0d: empty sequence, done", n_txn);
               n_txn++;
            end else begin
               m_run = 1; m_pos = 0; m_gap = 0; m_elapsed = 0;
            end
         end
      end else if (m_gap) begin
         m_pos++;
         m_gap = 0;
         m_elapsed = 0;
         if (m_pos == plan.size()) begin
            m_run  = 0;
            m_done = 1;
            $display("txn %0d: completed %0d passes", n_txn, plan.size());
            n_txn++;
         end
      end else if (end_in[ow]) begin
         m_gap = 1;
      end else if (m_tmo != 0 && m_elapsed == m_tmo - 1) begin
         m_run = 0; m_err = 1; m_err_idx = ow;
         $display("txn %0d: timeout on client %0d", n_txn, ow);
         n_txn++;
      end else begin
         m_elapsed++;
      end
   endtask

   // Called at a falling edge with inputs set; checks, then steps the model
   task automatic tick();
      ctrl_in = {$urandom(), $urandom(), $urandom()};
      #1;
      compare();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic clear();
      rst = 0; en = 1; start_in = 0; abort_in = 0; end_in = '0;
   endtask

   task automatic launch(input logic [N-1:0] m, input logic p, input int t);
      clear();
      start_in = 1; mode_in = m; pre_in = p; tmo_in = TW'(t);
      tick();
      clear();
   endtask

   // Owner runs for w cycles, strobes its end, then the gap cycle passes
   task automatic serve(input int w);
      int ow;
      for (int c = 0; c < w; c++) tick();
      ow = m_owner();
      if (ow >= 0) end_in[ow] = 1'b1;
      tick();
      clear();
      tick();
   endtask

   initial begin
      rst = 1; en = 1; start_in = 0; abort_in = 0; end_in = '0;
      mode_in = '0; pre_in = 0; tmo_in = '0; ctrl_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tick();
      clear();
      check("rst_ctrl", o_ctrl, IDLE_E);
      check("rst_busy", 32'(o_busy), 32'd0);

      // 1: reset pass then clients 0 and 1
      launch(3'b011, 1'b1, 0);
      serve(5); serve(5); serve(5);
      check("t1_done", 32'(o_done), 32'd1);
      tick();

      // 2: spurious strobe from a non-owner is ignored
      launch(3'b101, 1'b0, 0);
      end_in = 3'b010;
      repeat (3) tick();
      clear();
      serve(0);
      check("t2_idx", 32'(o_active_idx), 32'd2);
      serve(2);
      tick();

      // 3: watchdog expiry, then restart from error
      launch(3'b010, 1'b0, 8);
      repeat (8) tick();
      check("t3_error", 32'(o_error), 32'd1);
      check("t3_err_idx", 32'(o_err_idx), 32'd1);
      check("t3_go", 32'(o_go), 32'd0);
      launch(3'b001, 1'b0, 0);
      check("t3_restart_err", 32'(o_error), 32'd0);
      check("t3_restart_go", 32'(o_go), 32'd1);
      serve(1);
      tick();

      // 4: end strobe on the expiry cycle wins
      launch(3'b010, 1'b0, 8);
      repeat (7) tick();
      end_in = 3'b010;
      tick();
      clear();
      check("t4_error", 32'(o_error), 32'd0);
      check("t4_busy", 32'(o_busy), 32'd1);
      tick();
      check("t4_done", 32'(o_done), 32'd1);
      tick();

      // 5: abort beats a same-cycle end strobe
      launch(3'b111, 1'b0, 0);
      serve(2);
      tick();
      abort_in = 1; end_in = 3'b010;
      tick();
      clear();
      check("t5_busy", 32'(o_busy), 32'd0);
      check("t5_ctrl", o_ctrl, IDLE_E);
      check("t5_done", 32'(o_done), 32'd0);
      tick();

      // 6: reset mid-run, watchdog freeze under en low, deferred done
      launch(3'b011, 1'b0, 6);
      repeat (3) tick();
      rst = 1;
      tick();
      clear();
      check("t6_rst_busy", 32'(o_busy), 32'd0);
      check("t6_rst_ctrl", o_ctrl, IDLE_E);
      launch(3'b001, 1'b0, 6);
      repeat (2) tick();
      en = 0;
      repeat (4) tick();
      clear();
      check("t6_frozen", 32'(o_error), 32'd0);
      repeat (4) tick();
      check("t6_expire", 32'(o_error), 32'd1);
      launch(3'b001, 1'b0, 0);
      serve(1);
      en = 0;
      #1;
      check("t6_done_held", 32'(o_done), 32'd0);
      repeat (2) tick();
      clear();
      #1;
      check("t6_done_late", 32'(o_done), 32'd1);
      tick();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         clear();
         rst      = ($urandom_range(0, 199) == 0);
         en       = ($urandom_range(0, 9) != 0);
         abort_in = ($urandom_range(0, 49) == 0);
         start_in = ($urandom_range(0, 3) == 0);
         mode_in  = N'($urandom());
         pre_in   = ($urandom_range(0, 2) == 0);
         tmo_in   = ($urandom_range(0, 3) == 0) ? '0 : TW'($urandom_range(1, 12));
         for (int i = 0; i < N; i++) end_in[i] = ($urandom_range(0, 4) == 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
